// File: rtl/lifo_stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_pkg
//  Description : Shared definitions for the LIFO stack engine: the per-cycle
//                operation encoding and the request priority decode used by
//                the stack controller.
//  Revision    : 1.0  initial release
// ============================================================================
package lifo_pkg;

    // One operation is executed per cycle; reset is handled outside the decode.
    typedef enum logic [2:0] {
        OP_IDLE = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_REPL = 3'd3,
        OP_CLR  = 3'd4
    } op_e;

    // Priority: clear > push&pop > push > pop > idle.
    // A push&pop on an empty stack has nothing to replace, so it is a push.
    function automatic op_e decode_op(
        input logic clear,
        input logic push,
        input logic pop,
        input logic stack_empty
    );
        op_e op;
        op = OP_IDLE;
        if (clear) begin
            op = OP_CLR;
        end else if (push && pop) begin
            op = stack_empty ? OP_PUSH : OP_REPL;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_mem
//  Description : DATA_W x DEPTH storage array for the LIFO stack. One
//                synchronous write port, one combinational read port.
//  Revision    : 1.0  initial release
// ============================================================================
module lifo_mem
    import lifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port: contents are never cleared, only overwritten.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Combinational read so the controller can load dout on the pop edge.
    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/lifo_stack.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_stack
//  Description : Parametrised LIFO stack engine with single-cycle push, pop,
//                push+pop replace and clear. Registered top-of-stack output,
//                occupancy count, full/empty decode and overflow/underflow
//                flags. Define LIFO_STICKY_ERR_EN to make the error flags
//                hold until clear or reset; otherwise they are 1-cycle pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module lifo_stack
    import lifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_dout;
    logic              r_overflow;
    logic              r_underflow;

    op_e               w_op;
    logic              w_empty;
    logic              w_full;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [AW-1:0]     w_raddr;
    logic [DATA_W-1:0] w_rdata;
    logic              w_ovf_evt;
    logic              w_unf_evt;

    // Flags come from the registered count only, never from the requests.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    assign w_op = decode_op(clear, push, pop, w_empty);

    // Replace overwrites the current top; a push writes one slot above it.
    assign w_we    = !reset && ((w_op == OP_REPL) || (w_op == OP_PUSH && !w_full));
    assign w_waddr = (w_op == OP_REPL) ? AW'(r_count - CNT_W'(1)) : AW'(r_count);
    // Entry that becomes top after a pop (only meaningful when count >= 2).
    assign w_raddr = AW'(r_count - CNT_W'(2));

    assign w_ovf_evt = (w_op == OP_PUSH) && w_full;
    assign w_unf_evt = (w_op == OP_POP) && w_empty;

    lifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .we     (w_we),
        .waddr  (w_waddr),
        .wdata  (din),
        .raddr  (w_raddr),
        .rdata  (w_rdata)
    );

    // Occupancy and top-of-stack register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_dout  <= '0;
        end else begin
            case (w_op)
                OP_CLR: begin
                    r_count <= '0;
                    r_dout  <= '0;
                end
                OP_REPL: begin
                    r_dout <= din;
                end
                OP_PUSH: begin
                    if (!w_full) begin
                        r_count <= r_count + CNT_W'(1);
                        r_dout  <= din;
                    end
                end
                OP_POP: begin
                    if (!w_empty) begin
                        r_count <= r_count - CNT_W'(1);
                        r_dout  <= (r_count == CNT_W'(1)) ? '0 : w_rdata;
                    end
                end
                default: begin
                    r_count <= r_count;
                    r_dout  <= r_dout;
                end
            endcase
        end
    end

    // Error flags: raised on the edge that samples the rejected request.
    always_ff @(posedge clk) begin
        if (reset || (w_op == OP_CLR)) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
`ifdef LIFO_STICKY_ERR_EN
            r_overflow  <= r_overflow  | w_ovf_evt;
            r_underflow <= r_underflow | w_unf_evt;
`else
            r_overflow  <= w_ovf_evt;
            r_underflow <= w_unf_evt;
`endif
        end
    end

    assign dout      = r_dout;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire
